noc_net_iface: RTL and testbench
================================

Name: noc_net_iface

Overview:
- Per-node network interface between a local processing element and one NoC router's processor port.
- TX side takes payload plus destination on a synchronous valid/ready interface and buffers it in a FIFO. It packetizes each entry and drives the router's processor input using a 4-phase req/ack handshake.
- RX side accepts packets from the router's processor output using a 4-phase req/ack handshake and presents them to the PE on valid/ready.
- One instance sits on each node's processor port of the mesh.

Parameters:
- PAYLOAD, 32, payload width in bits
- X_BITS, 1, destination X field width
- Y_BITS, 1, destination Y field width
- SRC_X, 0, this node's X coordinate
- SRC_Y, 0, this node's Y coordinate
- DEPTH, 4, TX FIFO entries; power of two, >= 2
- PKT, X_BITS+Y_BITS+2+PAYLOAD, packet width (derived, not overridden)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- tx_valid  in  1  PE offers a packet
- tx_ready  out  1  FIFO not full
- tx_dst_x  in  X_BITS  destination X
- tx_dst_y  in  Y_BITS  destination Y
- tx_tag  in  2  packet tag
- tx_payload  in  PAYLOAD  payload
- net_req  out  1  4-phase request to router processor input
- net_ack  in  1  4-phase ack from router (asynchronous)
- net_data  out  PKT  packet to router
- net_rx_req  in  1  4-phase request from router processor output (asynchronous)
- net_rx_ack  out  1  4-phase ack to router
- net_rx_data  in  PKT  packet from router
- rx_valid  out  1  received packet available
- rx_ready  in  1  PE consumes packet
- rx_tag  out  2  received tag
- rx_payload  out  PAYLOAD  received payload
- rx_err  out  1  received destination does not equal (SRC_X, SRC_Y)

Behaviour:
- Reset (rst=0, asynchronous):
  - net_req, net_rx_ack, rx_valid and rx_err = 0.
  - net_data, rx_payload and rx_tag = 0.
  - tx_ready = 1.
  - FIFO emptied, synchronizers cleared, both FSMs to idle.
  - A packet in flight at reset is dropped. The router shares the same reset.
- Packet format, MSB to LSB: dst_x, dst_y, tag[1:0], payload.
- net_ack and net_rx_req each pass through a 2-flop synchronizer before use (ack_s, rxreq_s).
- TX FIFO:
  - Push on tx_valid && tx_ready.
  - tx_ready = !full; a push offered while full is ignored.
  - Pointers wrap modulo DEPTH. Order is preserved.
- TX FSM:
  - T_IDLE: if the FIFO is non-empty and ack_s=0, load net_data from the head, pop, set net_req=1, go to T_REQ. A push at edge E0 into an empty FIFO gives net_req=1 after E1.
  - T_REQ: on ack_s=1, set net_req=0 and go to T_REL.
  - T_REL: on ack_s=0, go to T_IDLE.
  - net_data is stable from the rise of net_req until T_IDLE is re-entered.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
- RX FSM:
  - R_IDLE: if rxreq_s=1 and the holding register is empty (or rx_ready is popping it this cycle), capture net_rx_data, set rx_valid=1 and net_rx_ack=1, go to R_ACK.
  - If the holding register is full, net_rx_ack stays 0. This is backpressure into the router.
  - R_ACK: on rxreq_s=0, set net_rx_ack=0 and go to R_IDLE.
  - rx_valid clears on rx_valid && rx_ready unless a new capture occurs in the same cycle.
  - rx_err is computed at capture as (dst_x!=SRC_X) || (dst_y!=SRC_Y). The packet is still delivered; rx_err is valid with rx_valid.
- The TX and RX paths are fully independent and may operate simultaneously.

Optional Feature:
- Macro NI_SEQ_TAG_EN.
- When defined: the tag field is a 2-bit sequence counter and tx_tag is ignored.
  - The counter resets to 0 and increments on each push, wrapping 3 to 0.
  - The value sampled at push is stored in the FIFO.
- When undefined: the tag field equals tx_tag as sampled at push.

Test Plan:
1. Reset check: hold rst=0 -> all outputs 0 and tx_ready=1. Assert rst low mid-T_REQ -> net_req=0 immediately, FIFO empty.
2. Single TX packet: push dst (1,0), tag 2'b10, payload 32'hDEADBEEF -> after one edge, net_data=36'hA_DEADBEEF and net_req=1. Raise net_ack -> net_req falls within 3 edges. Drop net_ack -> FSM idle, next packet launches.
3. TX backpressure with DEPTH=4 and net_ack held 0: push 6 packets -> 5 accepted (1 in net_data, 4 in FIFO), tx_ready=0 on the 6th. After 5 ack cycles, payloads emerge in push order.
4. RX delivery at node (0,0): net_rx_data={0,0,2'b01,32'h12345678}, net_rx_req=1 -> within 3 edges rx_valid=1, rx_payload=32'h12345678, rx_tag=1, rx_err=0, net_rx_ack=1. With rx_ready=0, a second request is not acked until the first is popped.
5. RX misroute: packet with dst (1,1) at SRC (0,0) -> rx_valid=1 with rx_err=1. Payload intact.
6. With NI_SEQ_TAG_EN defined: 5 pushes with tx_tag=3 -> net_data tags 0,1,2,3,0.

Source files
------------

// File: rtl/noc_net_iface.sv
// Per-node network interface: TX FIFO feeding a 4-phase sender, and a 4-phase receiver with a holding register.
// Define NI_SEQ_TAG_EN to replace tx_tag with a 2-bit sequence counter sampled at push.
module noc_net_iface #(
  parameter int PAYLOAD = 32,
  parameter int X_BITS  = 1,
  parameter int Y_BITS  = 1,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0,
  parameter int DEPTH   = 4,
  localparam int PKT    = X_BITS + Y_BITS + 2 + PAYLOAD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [X_BITS-1:0]  tx_dst_x,
  input  logic [Y_BITS-1:0]  tx_dst_y,
  input  logic [1:0]         tx_tag,
  input  logic [PAYLOAD-1:0] tx_payload,
  output logic               net_req,
  input  logic               net_ack,
  output logic [PKT-1:0]     net_data,
  input  logic               net_rx_req,
  output logic               net_rx_ack,
  input  logic [PKT-1:0]     net_rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [1:0]         rx_tag,
  output logic [PAYLOAD-1:0] rx_payload,
  output logic               rx_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [X_BITS-1:0] SRC_X_V = X_BITS'(SRC_X);
  localparam logic [Y_BITS-1:0] SRC_Y_V = Y_BITS'(SRC_Y);

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_e;
  typedef enum logic {R_IDLE, R_ACK} rx_state_e;

  logic [PKT-1:0]     fifo_mem [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               full, empty, push, pop;
  logic [1:0]         push_tag;
  logic [PKT-1:0]     push_pkt;
  logic [1:0]         ack_sync_q, ack_sync_d, rxreq_sync_q, rxreq_sync_d;
  logic               ack_s, rxreq_s;
  tx_state_e          tx_state_q, tx_state_d;
  logic               net_req_q, net_req_d;
  logic [PKT-1:0]     net_data_q, net_data_d;
  rx_state_e          rx_state_q, rx_state_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_err_q, rx_err_d;
  logic               net_rx_ack_q, net_rx_ack_d;
  logic [1:0]         rx_tag_q, rx_tag_d;
  logic [PAYLOAD-1:0] rx_payload_q, rx_payload_d;
  logic               capture;
  logic [X_BITS-1:0]  rx_dst_x;
  logic [Y_BITS-1:0]  rx_dst_y;

`ifdef NI_SEQ_TAG_EN
  logic [1:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (push) seq_d = seq_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seq_q <= '0;
    else      seq_q <= seq_d;
  end

  assign push_tag = seq_q;
`else
  assign push_tag = tx_tag;
`endif

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign push_pkt = {tx_dst_x, tx_dst_y, push_tag, tx_payload};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= push_pkt;
  end

  assign ack_sync_d   = {ack_sync_q[0], net_ack};
  assign rxreq_sync_d = {rxreq_sync_q[0], net_rx_req};
  assign ack_s        = ack_sync_q[1];
  assign rxreq_s      = rxreq_sync_q[1];

  always_comb begin
    tx_state_d = tx_state_q;
    net_req_d  = net_req_q;
    net_data_d = net_data_q;
    pop        = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!empty && !ack_s) begin
          net_data_d = fifo_mem[rd_ptr_q[AW-1:0]];
          pop        = 1'b1;
          net_req_d  = 1'b1;
          tx_state_d = T_REQ;
        end
      end
      T_REQ: begin
        if (ack_s) begin
          net_req_d  = 1'b0;
          tx_state_d = T_REL;
        end
      end
      T_REL: begin
        if (!ack_s) tx_state_d = T_IDLE;
      end
      default: begin
        net_req_d  = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  assign rx_dst_x = net_rx_data[PKT-1 -: X_BITS];
  assign rx_dst_y = net_rx_data[PAYLOAD+2 +: Y_BITS];
  // A capture may overlap the PE draining the holding register in the same cycle.
  assign capture  = (rx_state_q == R_IDLE) && rxreq_s && (!rx_valid_q || rx_ready);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_valid_d   = rx_valid_q;
    rx_err_d     = rx_err_q;
    rx_tag_d     = rx_tag_q;
    rx_payload_d = rx_payload_q;
    net_rx_ack_d = net_rx_ack_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (capture) begin
          rx_valid_d   = 1'b1;
          rx_payload_d = net_rx_data[PAYLOAD-1:0];
          rx_tag_d     = net_rx_data[PAYLOAD +: 2];
          rx_err_d     = (rx_dst_x != SRC_X_V) || (rx_dst_y != SRC_Y_V);
          net_rx_ack_d = 1'b1;
          rx_state_d   = R_ACK;
        end
      end
      R_ACK: begin
        if (!rxreq_s) begin
          net_rx_ack_d = 1'b0;
          rx_state_d   = R_IDLE;
        end
      end
      default: begin
        net_rx_ack_d = 1'b0;
        rx_state_d   = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ack_sync_q   <= '0;
      rxreq_sync_q <= '0;
      tx_state_q   <= T_IDLE;
      net_req_q    <= 1'b0;
      net_data_q   <= '0;
      rx_state_q   <= R_IDLE;
      rx_valid_q   <= 1'b0;
      rx_err_q     <= 1'b0;
      rx_tag_q     <= '0;
      rx_payload_q <= '0;
      net_rx_ack_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ack_sync_q   <= ack_sync_d;
      rxreq_sync_q <= rxreq_sync_d;
      tx_state_q   <= tx_state_d;
      net_req_q    <= net_req_d;
      net_data_q   <= net_data_d;
      rx_state_q   <= rx_state_d;
      rx_valid_q   <= rx_valid_d;
      rx_err_q     <= rx_err_d;
      rx_tag_q     <= rx_tag_d;
      rx_payload_q <= rx_payload_d;
      net_rx_ack_q <= net_rx_ack_d;
    end
  end

  assign net_req    = net_req_q;
  assign net_data   = net_data_q;
  assign net_rx_ack = net_rx_ack_q;
  assign rx_valid   = rx_valid_q;
  assign rx_err     = rx_err_q;
  assign rx_tag     = rx_tag_q;
  assign rx_payload = rx_payload_q;

endmodule

// File: tb/tb_noc_net_iface.sv
// Directed testbench for noc_net_iface (default parameters, node (0,0)).
// Expected tags follow NI_SEQ_TAG_EN when the bench is compiled with it.
module tb_noc_net_iface;

  localparam int PAYLOAD = 32;
  localparam int PKT     = 36;

  logic               clk;
  logic               rst;
  logic               tx_valid;
  logic               tx_ready;
  logic [0:0]         tx_dst_x;
  logic [0:0]         tx_dst_y;
  logic [1:0]         tx_tag;
  logic [PAYLOAD-1:0] tx_payload;
  logic               net_req;
  logic               net_ack;
  logic [PKT-1:0]     net_data;
  logic               net_rx_req;
  logic               net_rx_ack;
  logic [PKT-1:0]     net_rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [1:0]         rx_tag;
  logic [PAYLOAD-1:0] rx_payload;
  logic               rx_err;

  int nVec = 0;
  int nErr = 0;

  noc_net_iface dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_dst_x    (tx_dst_x),
    .tx_dst_y    (tx_dst_y),
    .tx_tag      (tx_tag),
    .tx_payload  (tx_payload),
    .net_req     (net_req),
    .net_ack     (net_ack),
    .net_data    (net_data),
    .net_rx_req  (net_rx_req),
    .net_rx_ack  (net_rx_ack),
    .net_rx_data (net_rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_tag      (rx_tag),
    .rx_payload  (rx_payload),
    .rx_err      (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic dx, input logic dy, input logic [1:0] tg,
                               input logic [PAYLOAD-1:0] pl);
    tx_valid   = 1'b1;
    tx_dst_x   = dx;
    tx_dst_y   = dy;
    tx_tag     = tg;
    tx_payload = pl;
  endtask

  // Full 4-phase cycle from T_REQ; ends one edge after the FSM is back in T_IDLE.
  task automatic ackCycle();
    net_ack = 1'b1;
    stepClk(3);
    net_ack = 1'b0;
    stepClk(4);
  endtask

  initial begin
    logic [1:0] expTag;
    rst = 1'b0;
    tx_valid = 1'b0; tx_dst_x = '0; tx_dst_y = '0; tx_tag = '0; tx_payload = '0;
    net_ack = 1'b0; net_rx_req = 1'b0; net_rx_data = '0; rx_ready = 1'b0;
    #3;
    checkOutput("rst_net_req", net_req, 0);
    checkOutput("rst_net_rx_ack", net_rx_ack, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_rx_err", rx_err, 0);
    checkOutput("rst_net_data", net_data, 0);
    checkOutput("rst_rx_payload", rx_payload, 0);
    checkOutput("rst_rx_tag", rx_tag, 0);
    checkOutput("rst_tx_ready", tx_ready, 1);
    stepClk(2);
    rst = 1'b1;
    stepClk(1);

    $display("[TB] single TX packet");
    applyStimulus(1'b1, 1'b0, 2'b10, 32'hDEADBEEF);
    stepClk(1);
    tx_valid = 1'b0;
    checkOutput("tx1_no_req_yet", net_req, 0);
    stepClk(1);
    checkOutput("tx1_net_req", net_req, 1);
`ifdef NI_SEQ_TAG_EN
    checkOutput("tx1_net_data", net_data, 36'h8DEADBEEF);
`else
    checkOutput("tx1_net_data", net_data, 36'hADEADBEEF);
`endif
    net_ack = 1'b1;
    stepClk(2);
    checkOutput("tx1_req_held", net_req, 1);
    stepClk(1);
    checkOutput("tx1_req_fall", net_req, 0);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h0BADF00D);
    net_ack = 1'b0;
    stepClk(1);
    tx_valid = 1'b0;
    stepClk(2);
    checkOutput("tx2_wait_idle", net_req, 0);
`ifdef NI_SEQ_TAG_EN
    checkOutput("tx1_data_stable", net_data, 36'h8DEADBEEF);
`else
    checkOutput("tx1_data_stable", net_data, 36'hADEADBEEF);
`endif
    stepClk(1);
    checkOutput("tx2_net_req", net_req, 1);
    checkOutput("tx2_net_data", net_data, 36'h50BADF00D);
    ackCycle();
    checkOutput("tx2_done", net_req, 0);

    $display("[TB] TX backpressure");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 32'h10000000 + i);
      checkOutput((i == 5) ? "bp_tx_ready_full" : "bp_tx_ready_open", tx_ready, (i == 5) ? 0 : 1);
      stepClk(1);
    end
    tx_valid = 1'b0;
    checkOutput("bp_still_full", tx_ready, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_net_req", net_req, 1);
      checkOutput("bp_payload_order", net_data[31:0], 32'h10000000 + i);
      ackCycle();
      if (i == 0) checkOutput("bp_slot_freed", tx_ready, 1);
    end
    checkOutput("bp_drained", net_req, 0);

    $display("[TB] reset during T_REQ");
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h11111111);
    stepClk(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h22222222);
    stepClk(1);
    tx_valid = 1'b0;
    checkOutput("mid_req_up", net_req, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_req", net_req, 0);
    checkOutput("mid_rst_data", net_data, 0);
    checkOutput("mid_rst_ready", tx_ready, 1);
    stepClk(1);
    rst = 1'b1;
    stepClk(3);
    checkOutput("mid_rst_fifo_empty", net_req, 0);

    $display("[TB] RX delivery");
    net_rx_data = 36'h112345678;
    net_rx_req  = 1'b1;
    stepClk(2);
    checkOutput("rx1_not_yet", rx_valid, 0);
    stepClk(1);
    checkOutput("rx1_valid", rx_valid, 1);
    checkOutput("rx1_payload", rx_payload, 32'h12345678);
    checkOutput("rx1_tag", rx_tag, 1);
    checkOutput("rx1_err", rx_err, 0);
    checkOutput("rx1_ack", net_rx_ack, 1);
    net_rx_req = 1'b0;
    stepClk(3);
    checkOutput("rx1_ack_release", net_rx_ack, 0);
    checkOutput("rx1_still_held", rx_valid, 1);
    net_rx_data = 36'hFCAFEF00D;
    net_rx_req  = 1'b1;
    stepClk(5);
    checkOutput("rx2_backpressure_ack", net_rx_ack, 0);
    checkOutput("rx2_old_payload", rx_payload, 32'h12345678);
    rx_ready = 1'b1;
    stepClk(1);
    rx_ready = 1'b0;
    checkOutput("rx2_valid", rx_valid, 1);
    checkOutput("rx2_payload", rx_payload, 32'hCAFEF00D);
    checkOutput("rx2_tag", rx_tag, 3);
    checkOutput("rx2_misroute_err", rx_err, 1);
    checkOutput("rx2_ack", net_rx_ack, 1);
    net_rx_req = 1'b0;
    stepClk(3);
    checkOutput("rx2_ack_release", net_rx_ack, 0);
    rx_ready = 1'b1;
    stepClk(1);
    rx_ready = 1'b0;
    checkOutput("rx2_popped", rx_valid, 0);

    $display("[TB] tag field");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b11, 32'hA0000000 + i);
      stepClk(1);
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef NI_SEQ_TAG_EN
      expTag = 2'(i);
`else
      expTag = 2'b11;
`endif
      checkOutput("tag_net_req", net_req, 1);
      checkOutput("tag_field", net_data[33:32], expTag);
      checkOutput("tag_payload", net_data[31:0], 32'hA0000000 + i);
      ackCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
